ecc_host_ctrl: RTL and testbench
================================

# ecc_host_ctrl

Initiator-side controller for the `ECC` point-multiplication core. It takes the 163-bit operands `g` and `k` as 32-bit register writes and drives `ecc_start` with a level handshake. It waits for `ecc_done`, captures the 176-bit `outxa`/`outza` results, and exposes them and a status word over the same simple 32-bit register port. It sits between the system register bus and the core, and owns handshake sequencing, operand freezing and timeout recovery.

## Interface
- `TIMEOUT`, default 4095: cycles allowed in RUN (and in RELEASE) before forced recovery; must be ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: register write strobe.
- `wr_addr` in 4: write word address.
- `wr_data` in 32: write data.
- `rd_en` in 1: register read strobe.
- `rd_addr` in 4: read word address.
- `rd_data` out 32: read data, registered.
- `rd_valid` out 1: high one cycle after `rd_en`.
- `irq` out 1: one-cycle pulse on completion or timeout.
- `ecc_start` out 1: level request to the core.
- `ecc_g` out 163: operand g, to the core.
- `ecc_k` out 163: operand k, to the core.
- `ecc_outxa` in 176: core result x.
- `ecc_outza` in 176: core result z.
- `ecc_done` in 1: core completion level.

## Operation
**Write map**
- 0–5: g words, little-endian; word 5 uses bits [2:0] only.
- 6–11: k words, same packing.
- 12: CTRL; bit0 = GO.
- All other addresses are ignored.

**Read map**
- 0–5: captured xa words; word 5 carries `xa[175:160]` in bits [15:0], upper bits zero.
- 6–11: captured za words, same packing.
- 13: STATUS = {29'b0, timeout, done, busy}.
- Unmapped addresses read 0.

**Operand writes**
- Writes to addresses 0–11 take effect only when `busy`=0.
- While busy they are dropped; operands stay frozen for the whole transaction.

**FSM**
- IDLE:
  - GO=1 clears `done` and `timeout`, clears the counter, sets `ecc_start`=1, and moves to RUN.
  - GO=0 has no effect.
- RUN (`ecc_start`=1, counter increments):
  - `ecc_done`=1 → capture both results, set `done`, pulse `irq`, set `ecc_start`=0, clear the counter, move to RELEASE.
  - Counter reaches TIMEOUT-1 first → set `timeout`, pulse `irq`, set `ecc_start`=0, move to RELEASE. Result registers are unchanged.
- RELEASE (`ecc_start`=0):
  - Wait for `ecc_done`=0, then move to IDLE.
  - If the counter reaches TIMEOUT-1 first, go to IDLE anyway and leave `timeout` set.

**Flags and boundaries**
- `busy` = (state ≠ IDLE).
- GO while busy is ignored.
- A write to CTRL with bit0=0 is a no-op.
- Simultaneous read and write: the read returns the pre-write value.
- `done` and `timeout` are sticky until the next accepted GO.
- Reset mid-transaction aborts immediately: `ecc_start` drops asynchronously and everything returns to reset values.

## Timing
**Reset values**
- `rd_data`=0, `rd_valid`=0, `irq`=0, `ecc_start`=0.
- `ecc_g`=0, `ecc_k`=0.
- Result registers 0.
- State IDLE; `done`, `timeout` and the counter all 0.

**Reads**
- `rd_data`/`rd_valid` are valid on the cycle after the `rd_en` edge.

**GO sequence, with GO accepted at edge E0**
- `ecc_start` is high after E0.
- With a 1-cycle core, `ecc_done` rises after E1. The controller captures at E2: `irq` pulses and `ecc_start` falls after E2.
- The core drops `ecc_done` after E3. The controller reaches IDLE at E4, so `busy` is low after E4.
- The captured result is readable from the cycle after E2.

**Pass-through**
- `ecc_g`/`ecc_k` are driven directly from the operand registers and are stable from before `ecc_start` rises until IDLE.

## Structure
- Shared package `ecc_pkg` holds:
  - `ECC_KEY_W`=163 and `ECC_OUT_W`=176.
  - Address constants `ADDR_G0`=0, `ADDR_K0`=6, `ADDR_CTRL`=12, `ADDR_STATUS`=13.
  - State enum `ecc_host_state_t` {IDLE, RUN, RELEASE}.
- One natural sub-module: `ecc_word_mux`, a combinational 176→32 word selector used twice for the xa/za read-back.
- The operand packing logic stays inline.

## Test plan
- **Write/read-back:** after reset, read addresses 0–13 → all 0.
  - Write g words = 1,2,3,4,5,7 → `ecc_g` = {3'h7, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1}.
- **Nominal:** pair with the `ECC` core (xa=0xa1b2c3d4, za=0xe5f60789), write GO.
  - `ecc_start` high for 2 cycles and one `irq` pulse.
  - Read addr 0 = 0xa1b2c3d4, addr 6 = 0xe5f60789, addr 5 = 0, STATUS = 0x2 after IDLE.
- **Timeout:** TIMEOUT=8, `ecc_done` tied 0, write GO.
  - `ecc_start` high exactly 8 cycles, `irq` pulse, STATUS = 0x4, results unchanged from the prior run.
- **Busy protection:** during RUN, write g word 0 = 0xdeadbeef and write GO again.
  - `ecc_g` unchanged and only one transaction completes.
- **Mid-op reset:** assert `rst_n`=0 in RUN.
  - `ecc_start` drops without waiting for a clock edge; after release, STATUS = 0 and all reads = 0.
- **Back-to-back:** GO issued on the first IDLE cycle after a completed run is accepted.
  - `done` clears on acceptance and sets again on the second completion.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared constants, register map and state encoding for the ECC host controller.
// Kept apart from the controller so the core wrapper and bus glue can share the map.
package ecc_pkg;

    localparam int ECC_KEY_W = 163;
    localparam int ECC_OUT_W = 176;

    localparam logic [3:0] ADDR_G0     = 4'd0;
    localparam logic [3:0] ADDR_K0     = 4'd6;
    localparam logic [3:0] ADDR_CTRL   = 4'd12;
    localparam logic [3:0] ADDR_STATUS = 4'd13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } ecc_host_state_t;

    function automatic logic [31:0] status_word(input logic timeout, input logic done,
                                                input logic busy);
        return {29'b0, timeout, done, busy};
    endfunction

endpackage

// File: rtl/ecc_host_ctrl_if.sv
// Register-bus and core-handshake signals of the ECC host controller.
// The controller connects through the slave modport; the bus/core side uses master.
interface ecc_host_ctrl_if;
    import ecc_pkg::*;

    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [31:0]          wr_data;
    logic                 rd_en;
    logic [3:0]           rd_addr;
    logic [31:0]          rd_data;
    logic                 rd_valid;
    logic                 irq;
    logic                 ecc_start;
    logic [ECC_KEY_W-1:0] ecc_g;
    logic [ECC_KEY_W-1:0] ecc_k;
    logic [ECC_OUT_W-1:0] ecc_outxa;
    logic [ECC_OUT_W-1:0] ecc_outza;
    logic                 ecc_done;

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, ecc_outxa, ecc_outza, ecc_done,
        output rd_data, rd_valid, irq, ecc_start, ecc_g, ecc_k
    );

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, ecc_outxa, ecc_outza, ecc_done,
        input  rd_data, rd_valid, irq, ecc_start, ecc_g, ecc_k
    );

endinterface

// File: rtl/ecc_word_mux.sv
// Selects one 32-bit read word out of a 176-bit captured result.
// Word 5 holds only the top 16 bits, zero-extended; selects above 5 read 0.
module ecc_word_mux
    import ecc_pkg::*;
(
    input  logic [ECC_OUT_W-1:0] data_i,
    input  logic [2:0]           sel_i,
    output logic [31:0]          word_o
);

    always_comb begin
        word_o = '0;
        case (sel_i)
            3'd0:    word_o = data_i[31:0];
            3'd1:    word_o = data_i[63:32];
            3'd2:    word_o = data_i[95:64];
            3'd3:    word_o = data_i[127:96];
            3'd4:    word_o = data_i[159:128];
            3'd5:    word_o = {16'b0, data_i[175:160]};
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/ecc_host_ctrl.sv
// Initiator-side controller for the ECC point-multiplication core: operand loading,
// level start/done handshake, result capture, timeout recovery and register read-back.
module ecc_host_ctrl
    import ecc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic           clk,
    input  logic           rst_n,
    ecc_host_ctrl_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_RUN     = RUN;
    localparam logic [1:0] S_RELEASE = RELEASE;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 irq_q, irq_d;
    logic [ECC_KEY_W-1:0] g_q, g_d, k_q, k_d;
    logic [ECC_OUT_W-1:0] xa_q, xa_d, za_q, za_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 rd_valid_q;

    logic        busy, go, cnt_last;
    logic [31:0] xa_word, za_word, rd_word;

    assign busy     = (state_q != S_IDLE);
    assign go       = bus.wr_en && (bus.wr_addr == ADDR_CTRL) && bus.wr_data[0];
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        g_d = g_q;
        k_d = k_q;
        // Operands are frozen for the whole transaction; writes while busy are dropped.
        if (bus.wr_en && !busy) begin
            for (int i = 0; i < 5; i++) begin
                if (bus.wr_addr == 4'(ADDR_G0 + i)) g_d[i*32 +: 32] = bus.wr_data;
                if (bus.wr_addr == 4'(ADDR_K0 + i)) k_d[i*32 +: 32] = bus.wr_data;
            end
            if (bus.wr_addr == 4'(ADDR_G0 + 5)) g_d[162:160] = bus.wr_data[2:0];
            if (bus.wr_addr == 4'(ADDR_K0 + 5)) k_d[162:160] = bus.wr_data[2:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        irq_d     = 1'b0;
        xa_d      = xa_q;
        za_d      = za_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.ecc_done) begin
                    xa_d    = bus.ecc_outxa;
                    za_d    = bus.ecc_outza;
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_last) begin
                    timeout_d = 1'b1;
                    irq_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                // A core that never drops done must not wedge the controller.
                if (!bus.ecc_done) begin
                    state_d = S_IDLE;
                end else if (cnt_last) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    ecc_word_mux u_xa_mux (
        .data_i (xa_q),
        .sel_i  (bus.rd_addr[2:0]),
        .word_o (xa_word)
    );

    ecc_word_mux u_za_mux (
        .data_i (za_q),
        .sel_i  (3'(bus.rd_addr - ADDR_K0)),
        .word_o (za_word)
    );

    always_comb begin
        rd_word = '0;
        if (bus.rd_addr < ADDR_K0)           rd_word = xa_word;
        else if (bus.rd_addr < ADDR_CTRL)    rd_word = za_word;
        else if (bus.rd_addr == ADDR_STATUS) rd_word = status_word(timeout_q, done_q, busy);
        rd_data_d = bus.rd_en ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            irq_q      <= 1'b0;
            g_q        <= '0;
            k_q        <= '0;
            xa_q       <= '0;
            za_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            irq_q      <= irq_d;
            g_q        <= g_d;
            k_q        <= k_d;
            xa_q       <= xa_d;
            za_q       <= za_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= bus.rd_en;
        end
    end

    // Start follows the state register, so an async reset drops it immediately.
    assign bus.ecc_start = (state_q == S_RUN);
    assign bus.ecc_g     = g_q;
    assign bus.ecc_k     = k_q;
    assign bus.irq       = irq_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_ecc_host_ctrl.sv
// Directed bench for ecc_host_ctrl with a 1-cycle core model; read data is checked
// through an expected-value queue popped by an independent monitor.
module tb_ecc_host_ctrl;
    import ecc_pkg::*;

    typedef struct {
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    logic tie_done_low;
    logic [ECC_OUT_W-1:0] xa_val, za_val;

    exp_t sb_q[$];
    int   checks, failures;
    int   mon_checks, mon_failures;
    int   start_cnt, irq_cnt;
    int   s0, i0;

    ecc_host_ctrl_if bus ();

    ecc_host_ctrl #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ecc_outxa = xa_val;
    assign bus.ecc_outza = za_val;

    // Core model: done follows start one cycle later, unless forced low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.ecc_done <= 1'b0;
        else        bus.ecc_done <= bus.ecc_start && !tie_done_low;
    end

    always @(negedge clk) begin
        exp_t x;
        if (bus.ecc_start) start_cnt++;
        if (bus.irq)       irq_cnt++;
        if (bus.rd_valid) begin
            mon_checks++;
            if (sb_q.size() == 0) begin
                mon_failures++;
                $display("FAIL unexpected_rd_valid got=%h exp=none", bus.rd_data);
            end else begin
                x = sb_q.pop_front();
                if (bus.rd_data !== x.val) begin
                    mon_failures++;
                    $display("FAIL %s got=%h exp=%h", x.tag, bus.rd_data, x.val);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [175:0] act, input logic [175:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string tag);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        sb_q.push_back('{val: e, tag: tag});
        @(negedge clk);
        bus.rd_en   = 1'b0;
    endtask

    task automatic wait_irq(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.irq && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 176'(bus.irq), 176'(1));
    endtask

    logic [ECC_KEY_W-1:0] g_exp, k_exp;

    initial begin
        checks = 0; failures = 0; mon_checks = 0; mon_failures = 0;
        start_cnt = 0; irq_cnt = 0;
        rst_n = 1'b0;
        tie_done_low = 1'b0;
        xa_val = '0; za_val = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        g_exp = {3'h7, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
        k_exp = {3'h6, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        repeat (3) @(negedge clk);
        chk("rst_ecc_start", 176'(bus.ecc_start), 176'(0));
        chk("rst_irq", 176'(bus.irq), 176'(0));
        chk("rst_rd_valid", 176'(bus.rd_valid), 176'(0));
        chk("rst_rd_data", 176'(bus.rd_data), 176'(0));
        chk("rst_ecc_g", 176'(bus.ecc_g), 176'(0));
        chk("rst_ecc_k", 176'(bus.ecc_k), 176'(0));
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 14; a++) rd(4'(a), 32'h0, "rst_read");

        wr(4'd0, 32'h1); wr(4'd1, 32'h2); wr(4'd2, 32'h3);
        wr(4'd3, 32'h4); wr(4'd4, 32'h5); wr(4'd5, 32'h7);
        wr(4'd6, 32'h11111111); wr(4'd7, 32'h22222222); wr(4'd8, 32'h33333333);
        wr(4'd9, 32'h44444444); wr(4'd10, 32'h55555555); wr(4'd11, 32'hfffffffe);
        wr(4'd12, 32'h0);
        wr(4'd14, 32'hffffffff);
        chk("load_ecc_g", 176'(bus.ecc_g), 176'(g_exp));
        chk("load_ecc_k", 176'(bus.ecc_k), 176'(k_exp));
        chk("ctrl_zero_noop", 176'(bus.ecc_start), 176'(0));
        rd(4'd13, 32'h0, "status_before_go");

        // Nominal run
        xa_val = 176'h0a1b2c3d4 & 176'hffffffff;
        za_val = 176'he5f60789;
        s0 = start_cnt; i0 = irq_cnt;
        wr(ADDR_CTRL, 32'h1);
        wait_irq(20, "nom_irq_seen");
        repeat (4) @(negedge clk);
        chk("nom_start_cycles", 176'(start_cnt - s0), 176'(2));
        chk("nom_irq_pulses", 176'(irq_cnt - i0), 176'(1));
        rd(4'd0, 32'ha1b2c3d4, "nom_xa0");
        rd(4'd6, 32'he5f60789, "nom_za0");
        rd(4'd5, 32'h0, "nom_xa5");
        rd(4'd13, 32'h2, "nom_status");

        // Timeout run with busy-time writes
        tie_done_low = 1'b1;
        xa_val = 176'h12345678;
        za_val = 176'h9abcdef0;
        s0 = start_cnt; i0 = irq_cnt;
        wr(ADDR_CTRL, 32'h1);
        wr(4'd0, 32'hdeadbeef);
        wr(ADDR_CTRL, 32'h1);
        chk("busy_ecc_g_frozen", 176'(bus.ecc_g), 176'(g_exp));
        rd(4'd13, 32'h1, "busy_status");
        wait_irq(20, "to_irq_seen");
        repeat (20) @(negedge clk);
        chk("to_start_cycles", 176'(start_cnt - s0), 176'(8));
        chk("to_irq_pulses", 176'(irq_cnt - i0), 176'(1));
        chk("to_ecc_g_after", 176'(bus.ecc_g), 176'(g_exp));
        rd(4'd13, 32'h4, "to_status");
        rd(4'd0, 32'ha1b2c3d4, "to_xa0_kept");
        rd(4'd6, 32'he5f60789, "to_za0_kept");

        // Back-to-back: second GO on the first IDLE cycle
        tie_done_low = 1'b0;
        xa_val = 176'h0badf00d;
        s0 = start_cnt; i0 = irq_cnt;
        wr(ADDR_CTRL, 32'h1);
        wait_irq(20, "b2b_irq1_seen");
        @(negedge clk);
        @(negedge clk);
        wr(ADDR_CTRL, 32'h1);
        rd(4'd13, 32'h1, "b2b_done_cleared");
        wait_irq(20, "b2b_irq2_seen");
        repeat (4) @(negedge clk);
        chk("b2b_start_cycles", 176'(start_cnt - s0), 176'(4));
        chk("b2b_irq_pulses", 176'(irq_cnt - i0), 176'(2));
        rd(4'd13, 32'h2, "b2b_status");
        rd(4'd0, 32'h0badf00d, "b2b_xa0");

        // Mid-operation reset
        tie_done_low = 1'b1;
        wr(ADDR_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        chk("mid_start_high", 176'(bus.ecc_start), 176'(1));
        #2 rst_n = 1'b0;
        #1 chk("mid_async_drop", 176'(bus.ecc_start), 176'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tie_done_low = 1'b0;
        @(negedge clk);
        chk("mid_ecc_g_cleared", 176'(bus.ecc_g), 176'(0));
        for (int a = 0; a < 14; a++) rd(4'(a), 32'h0, "mid_read");

        for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(negedge clk);
        chk("sb_drained", 176'(sb_q.size()), 176'(0));
        checks   += mon_checks;
        failures += mon_failures;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
